// File: rtl/coco_reset_pkg.sv
// Shared types and constants for the dragoncoco reset sequencer.
//   seq_state_t : sequencer state encoding, also exported on seq_state
//   CAUSE_*     : bit positions inside reset_cause
package coco_reset_pkg;

    typedef enum logic [2:0] {
        POR      = 3'd0,
        HARD     = 3'd1,
        WAIT_ROM = 3'd2,
        SOFT     = 3'd3,
        RUN      = 3'd4
    } seq_state_t;

    localparam int unsigned CAUSE_W    = 4;
    localparam int unsigned CAUSE_POR  = 0;
    localparam int unsigned CAUSE_HREQ = 1;
    localparam int unsigned CAUSE_DL   = 2;
    localparam int unsigned CAUSE_CFG  = 3;

endpackage

// File: rtl/coco_edge_detect.sv
// Registers a W-bit input every cycle and flags changes against that copy.
//   clk, reset_n : clock, asynchronous active-low reset (copy clears to 0)
//   d            : input vector
//   change_c     : any bit of d differs from its registered copy (combinational)
//   fall_c       : per-bit falling edge, copy=1 and d=0 (combinational)
module coco_edge_detect #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic         change_c,
    output logic [W-1:0] fall_c
);

    logic [W-1:0] d_q;

    // Previous-cycle copy of the input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q <= '0;
        end else begin
            d_q <= d;
        end
    end

    assign change_c = (d != d_q);
    assign fall_c   = d_q & ~d;

endmodule

// File: rtl/coco_reset_sequencer.sv
// Reset sequencer between the MiST top level and the dragoncoco core. Orders PLL
// lock, OSD/button requests, ROM download and watched config bits into a stretched
// hard_reset followed by a minimum-width core reset.
//   clk, reset_n    : 57.272 MHz clock, asynchronous active-low reset
//   pll_locked      : low forces POR on the next edge
//   cfg             : watched config bits, any toggle is a hard trigger
//   hard_req        : OSD hard reset | cartridge remove (level)
//   soft_req        : OSD reset | board button (level)
//   ioctl_download  : data_io download active, also a hard trigger
//   hard_reset      : registered hard reset to the core
//   reset           : registered core reset, active high
//   rom_loaded      : sticky, first download has completed
//   seq_state       : current sequencer state
//   reset_cause     : {CFG,DL,HREQ,POR} of the current/last hard reset
// Optional feature: define RESET_CAUSE_EN to build the reset_cause registers;
// without it reset_cause reads 4'b0000.
module coco_reset_sequencer
    import coco_reset_pkg::*;
#(
    parameter int unsigned NUM_CFG     = 2,
    parameter int unsigned HARD_CNT_W  = 16,
    parameter int unsigned HARD_HOLD   = 16'hFFFF,
    parameter int unsigned SOFT_MIN    = 16,
    parameter bit          REQUIRE_ROM = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic [NUM_CFG-1:0] cfg,
    input  logic               hard_req,
    input  logic               soft_req,
    input  logic               ioctl_download,
    output logic               hard_reset,
    output logic               reset,
    output logic               rom_loaded,
    output seq_state_t         seq_state,
    output logic [3:0]         reset_cause
);

    localparam int unsigned SOFT_W = $clog2(SOFT_MIN + 1);
    localparam logic [HARD_CNT_W-1:0] HOLD_INIT   = HARD_CNT_W'(HARD_HOLD);
    // Entry into SOFT counts the entry edge itself; a held soft_req restarts the
    // full SOFT_MIN window from the first edge that sees it low.
    localparam logic [SOFT_W-1:0]     SOFT_INIT   = SOFT_W'(SOFT_MIN - 1);
    localparam logic [SOFT_W-1:0]     SOFT_RELOAD = SOFT_W'(SOFT_MIN);

    // Parameter sanity checks at elaboration
    if ((64'(HARD_HOLD) >> HARD_CNT_W) != 64'd0) begin : g_hold_chk
        $error("HARD_HOLD does not fit in HARD_CNT_W bits");
    end
    if (SOFT_MIN < 1) begin : g_soft_chk
        $error("SOFT_MIN must be at least 1");
    end

    seq_state_t              state_q, state_d;
    logic [HARD_CNT_W-1:0]   hcnt_q, hcnt_d;
    logic [SOFT_W-1:0]       scnt_q, scnt_d;
    logic                    cfg_primed;
    logic                    cfg_change;
    logic [NUM_CFG-1:0]      cfg_fall;
    logic                    dl_change;
    logic                    dl_fall;
    logic                    cfg_trig;
    logic                    hard_trig;

    coco_edge_detect #(.W(NUM_CFG)) u_cfg_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .d        (cfg),
        .change_c (cfg_change),
        .fall_c   (cfg_fall)
    );

    coco_edge_detect #(.W(1)) u_dl_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .d        (ioctl_download),
        .change_c (dl_change),
        .fall_c   (dl_fall)
    );

    logic unused_edge;
    assign unused_edge = ^{cfg_fall, dl_change};

    // cfg_q is garbage until the first edge out of POR, so ignore changes until then
    assign cfg_trig  = cfg_primed & cfg_change;
    assign hard_trig = hard_req | ioctl_download | cfg_trig;

    // Next state and counters; lock loss beats hard trigger beats soft_req
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        scnt_d  = scnt_q;
        if (!pll_locked) begin
            state_d = POR;
            hcnt_d  = '0;
            scnt_d  = '0;
        end else begin
            case (state_q)
                POR: begin
                    state_d = HARD;
                    hcnt_d  = HOLD_INIT;
                end
                HARD: begin
                    if (hard_trig) begin
                        hcnt_d = HOLD_INIT;
                    end else if (hcnt_q != '0) begin
                        hcnt_d = hcnt_q - HARD_CNT_W'(1);
                    end else if (rom_loaded || !REQUIRE_ROM) begin
                        state_d = SOFT;
                        scnt_d  = SOFT_INIT;
                    end else begin
                        state_d = WAIT_ROM;
                    end
                end
                WAIT_ROM: begin
                    if (hard_trig) begin
                        state_d = HARD;
                        hcnt_d  = HOLD_INIT;
                    end else if (rom_loaded) begin
                        state_d = SOFT;
                        scnt_d  = SOFT_INIT;
                    end
                end
                SOFT: begin
                    if (hard_trig) begin
                        state_d = HARD;
                        hcnt_d  = HOLD_INIT;
                    end else if (soft_req) begin
                        scnt_d = SOFT_RELOAD;
                    end else if (scnt_q != '0) begin
                        scnt_d = scnt_q - SOFT_W'(1);
                    end else begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (hard_trig) begin
                        state_d = HARD;
                        hcnt_d  = HOLD_INIT;
                    end else if (soft_req) begin
                        state_d = SOFT;
                        scnt_d  = SOFT_INIT;
                    end
                end
                default: begin
                    state_d = POR;
                end
            endcase
        end
    end

    // State, counters and registered decodes of the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= POR;
            hcnt_q     <= '0;
            scnt_q     <= '0;
            hard_reset <= 1'b1;
            reset      <= 1'b1;
            rom_loaded <= 1'b0;
            cfg_primed <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            scnt_q     <= scnt_d;
            hard_reset <= (state_d == POR) || (state_d == HARD);
            reset      <= (state_d != RUN);
            // SDRAM is re-initialised on lock loss, so the ROM image is gone too
            rom_loaded <= pll_locked && (rom_loaded || ((state_q != POR) && dl_fall));
            cfg_primed <= pll_locked && (state_q != POR);
        end
    end

    assign seq_state = state_q;

`ifdef RESET_CAUSE_EN
    logic [CAUSE_W-1:0] cause_src;
    logic [CAUSE_W-1:0] cause_q;

    // Trigger sources seen this cycle
    always_comb begin
        cause_src             = '0;
        cause_src[CAUSE_HREQ] = hard_req;
        cause_src[CAUSE_DL]   = ioctl_download;
        cause_src[CAUSE_CFG]  = cfg_trig;
    end

    // A fresh hard reset from SOFT/RUN restarts the record; the first download out
    // of WAIT_ROM is still part of power-up, so the POR bit is kept there.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= CAUSE_W'(1) << CAUSE_POR;
        end else if (state_d == POR) begin
            cause_q <= CAUSE_W'(1) << CAUSE_POR;
        end else if ((state_d == HARD) && ((state_q == SOFT) || (state_q == RUN))) begin
            cause_q <= cause_src;
        end else if ((state_q == POR) || (state_q == HARD) || (state_d == HARD)) begin
            cause_q <= cause_q | cause_src;
        end
    end

    assign reset_cause = cause_q;
`else
    assign reset_cause = 4'b0000;
`endif

endmodule

// File: tb/tb_coco_reset_sequencer.sv
// Self-checking bench for coco_reset_sequencer (HARD_HOLD=8, SOFT_MIN=4).
// A deadline-based model predicts every output after each clock edge.
module tb_coco_reset_sequencer;

    localparam int HOLD = 8;
    localparam int SMIN = 4;
    localparam logic [2:0] P_POR  = 3'd0;
    localparam logic [2:0] P_HARD = 3'd1;
    localparam logic [2:0] P_WAIT = 3'd2;
    localparam logic [2:0] P_SOFT = 3'd3;
    localparam logic [2:0] P_RUN  = 3'd4;
`ifdef RESET_CAUSE_EN
    localparam bit CAUSE_ON = 1'b1;
`else
    localparam bit CAUSE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic [1:0] cfg;
    logic       hard_req;
    logic       soft_req;
    logic       ioctl_download;
    logic       hard_reset;
    logic       reset;
    logic       rom_loaded;
    logic [2:0] seq_state;
    logic [3:0] reset_cause;

    int errors = 0;
    int checks = 0;

    // model: phase, deadlines (edge numbers) and sticky flags
    logic [2:0] m_ph;
    logic       m_rom;
    logic       m_primed;
    logic [1:0] m_cfg_prev;
    logic       m_dl_prev;
    logic [3:0] m_cause;
    int         m_n = 0;
    int         m_hard_end = 0;
    int         m_soft_end = 0;

    coco_reset_sequencer #(
        .NUM_CFG     (2),
        .HARD_CNT_W  (16),
        .HARD_HOLD   (HOLD),
        .SOFT_MIN    (SMIN),
        .REQUIRE_ROM (1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .cfg            (cfg),
        .hard_req       (hard_req),
        .soft_req       (soft_req),
        .ioctl_download (ioctl_download),
        .hard_reset     (hard_reset),
        .reset          (reset),
        .rom_loaded     (rom_loaded),
        .seq_state      (seq_state),
        .reset_cause    (reset_cause)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_ph       = P_POR;
        m_rom      = 1'b0;
        m_primed   = 1'b0;
        m_cfg_prev = 2'b00;
        m_dl_prev  = 1'b0;
        m_cause    = 4'b0001;
    endfunction

    // One clock edge of the reference behaviour, using the inputs held since the last negedge
    function automatic void model_step();
        logic [3:0] src;
        logic       trig;
        logic       fell;
        logic [2:0] ph0;
        logic       rom0;
        m_n = m_n + 1;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ph0  = m_ph;
        rom0 = m_rom;
        src  = {m_primed && (cfg != m_cfg_prev), ioctl_download, hard_req, 1'b0};
        trig = |src;
        fell = m_dl_prev && !ioctl_download;
        if (!pll_locked) begin
            m_ph    = P_POR;
            m_cause = 4'b0001;
        end else begin
            case (ph0)
                P_POR: begin
                    m_ph       = P_HARD;
                    m_hard_end = m_n + HOLD + 1;
                    m_cause    = m_cause | src;
                end
                P_HARD: begin
                    if (trig) begin
                        m_hard_end = m_n + HOLD + 1;
                        m_cause    = m_cause | src;
                    end else if (m_n >= m_hard_end) begin
                        if (rom0) begin
                            m_ph       = P_SOFT;
                            m_soft_end = m_n + SMIN;
                        end else begin
                            m_ph = P_WAIT;
                        end
                    end
                end
                P_WAIT: begin
                    if (trig) begin
                        m_ph       = P_HARD;
                        m_hard_end = m_n + HOLD + 1;
                        m_cause    = m_cause | src;
                    end else if (rom0) begin
                        m_ph       = P_SOFT;
                        m_soft_end = m_n + SMIN;
                    end
                end
                P_SOFT: begin
                    if (trig) begin
                        m_ph       = P_HARD;
                        m_hard_end = m_n + HOLD + 1;
                        m_cause    = src;
                    end else if (soft_req) begin
                        m_soft_end = m_n + SMIN + 1;
                    end else if (m_n >= m_soft_end) begin
                        m_ph = P_RUN;
                    end
                end
                P_RUN: begin
                    if (trig) begin
                        m_ph       = P_HARD;
                        m_hard_end = m_n + HOLD + 1;
                        m_cause    = src;
                    end else if (soft_req) begin
                        m_ph       = P_SOFT;
                        m_soft_end = m_n + SMIN;
                    end
                end
                default: m_ph = P_POR;
            endcase
        end
        m_rom      = pll_locked && (rom0 || ((ph0 != P_POR) && fell));
        m_primed   = pll_locked && (ph0 != P_POR);
        m_cfg_prev = cfg;
        m_dl_prev  = ioctl_download;
    endfunction

    function automatic logic [9:0] expect_vec();
        logic [3:0] c;
        c = CAUSE_ON ? m_cause : 4'b0000;
        return {(m_ph == P_POR) || (m_ph == P_HARD), m_ph != P_RUN, m_rom, m_ph, c};
    endfunction

    function automatic logic [9:0] obs();
        return {hard_reset, reset, rom_loaded, seq_state, reset_cause};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pll_locked = 1'b0; cfg = 2'b00;
        hard_req = 1'b0; soft_req = 1'b0; ioctl_download = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({hard_reset, reset, rom_loaded, seq_state} !== 6'b110_000) begin
            errors++;
            $display("FAIL reset_values: got %b want 110000", {hard_reset, reset, rom_loaded, seq_state});
        end
        checks++;
        if (reset_cause !== (CAUSE_ON ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL reset_cause_init: got %b", reset_cause);
        end
    endtask

    task automatic test_por();
        int n;
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (obs() !== expect_vec()) begin
                errors++;
                $display("FAIL por_wait %0d: got %b want %b", c, obs(), expect_vec());
            end
        end
        pll_locked = 1'b1;
        tick();
        n = 0;
        while (hard_reset === 1'b1 && n < 40) begin
            tick();
            n++;
            checks++;
            if (obs() !== expect_vec()) begin
                errors++;
                $display("FAIL por_hard %0d: got %b want %b", n, obs(), expect_vec());
            end
        end
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL por_hold_len: got %0d edges want %0d", n, HOLD + 1);
        end
        checks++;
        if ({reset, rom_loaded, seq_state, reset_cause} !== {2'b10, P_WAIT, CAUSE_ON ? 4'b0001 : 4'b0000}) begin
            errors++;
            $display("FAIL por_end: got r=%b rom=%b st=%0d cause=%b", reset, rom_loaded, seq_state, reset_cause);
        end
    endtask

    task automatic test_download();
        int n;
        ioctl_download = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (hard_reset !== 1'b1 || obs() !== expect_vec()) begin
                errors++;
                $display("FAIL dl_active %0d: got %b want %b", c, obs(), expect_vec());
            end
        end
        ioctl_download = 1'b0;
        tick();
        n = 1;
        checks++;
        if (rom_loaded !== 1'b1) begin
            errors++;
            $display("FAIL dl_rom_loaded: got %b want 1", rom_loaded);
        end
        while (hard_reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL dl_hold_len: got %0d edges want %0d", n, HOLD + 1);
        end
        n = 0;
        while (reset === 1'b1 && n < 40) begin
            tick();
            n++;
            checks++;
            if (obs() !== expect_vec()) begin
                errors++;
                $display("FAIL dl_soft %0d: got %b want %b", n, obs(), expect_vec());
            end
        end
        checks++;
        if (n !== SMIN) begin
            errors++;
            $display("FAIL dl_soft_len: got %0d edges want %0d", n, SMIN);
        end
        checks++;
        if (seq_state !== P_RUN || reset_cause !== (CAUSE_ON ? 4'b0101 : 4'b0000)) begin
            errors++;
            $display("FAIL dl_end: got st=%0d cause=%b", seq_state, reset_cause);
        end
    endtask

    task automatic test_config();
        int n;
        cfg = cfg ^ 2'b10;
        tick();
        checks++;
        if (hard_reset !== 1'b1 || obs() !== expect_vec()) begin
            errors++;
            $display("FAIL cfg_trigger: got %b want %b", obs(), expect_vec());
        end
        n = 0;
        while (hard_reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== HOLD + 1) begin
            errors++;
            $display("FAIL cfg_hold_len: got %0d edges want %0d", n, HOLD + 1);
        end
        n = 0;
        while (reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== SMIN || seq_state !== P_RUN || rom_loaded !== 1'b1 ||
            reset_cause !== (CAUSE_ON ? 4'b1000 : 4'b0000)) begin
            errors++;
            $display("FAIL cfg_end: got len=%0d st=%0d rom=%b cause=%b", n, seq_state, rom_loaded, reset_cause);
        end
    endtask

    task automatic test_soft();
        int hi;
        int n;
        for (int pass = 0; pass < 2; pass++) begin
            hi = 0;
            soft_req = 1'b1;
            for (int c = 0; c < ((pass == 0) ? 1 : 10); c++) begin
                tick();
                if (reset === 1'b1) hi++;
            end
            soft_req = 1'b0;
            n = 0;
            while (reset === 1'b1 && n < 40) begin
                tick();
                n++;
                if (reset === 1'b1) hi++;
                checks++;
                if (hard_reset !== 1'b0 || obs() !== expect_vec()) begin
                    errors++;
                    $display("FAIL soft_step %0d/%0d: got %b want %b", pass, n, obs(), expect_vec());
                end
            end
            checks++;
            if (hi !== ((pass == 0) ? 4 : 14)) begin
                errors++;
                $display("FAIL soft_len_%0d: got %0d cycles want %0d", pass, hi, (pass == 0) ? 4 : 14);
            end
        end
    endtask

    task automatic test_collision();
        int n;
        hard_req = 1'b1;
        soft_req = 1'b1;
        tick();
        hard_req = 1'b0;
        soft_req = 1'b0;
        checks++;
        if (hard_reset !== 1'b1 || seq_state !== P_HARD ||
            reset_cause !== (CAUSE_ON ? 4'b0010 : 4'b0000)) begin
            errors++;
            $display("FAIL collision: got hr=%b st=%0d cause=%b", hard_reset, seq_state, reset_cause);
        end
        n = 0;
        while (reset === 1'b1 && n < 40) begin
            tick();
            n++;
            checks++;
            if (obs() !== expect_vec()) begin
                errors++;
                $display("FAIL collision_step %0d: got %b want %b", n, obs(), expect_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int n;
        hard_req = 1'b1;
        tick();
        hard_req = 1'b0;
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== {6'b110_000, CAUSE_ON ? 4'b0001 : 4'b0000}) begin
            errors++;
            $display("FAIL async_reset: got %b", obs());
        end
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        n = 0;
        while (seq_state !== P_WAIT && n < 40) begin
            tick();
            n++;
            checks++;
            if (obs() !== expect_vec()) begin
                errors++;
                $display("FAIL async_relock %0d: got %b want %b", n, obs(), expect_vec());
            end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        ioctl_download = 1'b1;
        repeat (3) tick();
        ioctl_download = 1'b0;
        n = 0;
        while (seq_state !== P_RUN && n < 40) begin
            tick();
            n++;
        end
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        tick();
        checks++;
        if (seq_state !== P_SOFT || obs() !== expect_vec()) begin
            errors++;
            $display("FAIL lock_pre: got %b want %b", obs(), expect_vec());
        end
        pll_locked = 1'b0;
        tick();
        checks++;
        if (obs() !== {6'b110_000, CAUSE_ON ? 4'b0001 : 4'b0000}) begin
            errors++;
            $display("FAIL lock_loss: got %b", obs());
        end
        repeat (3) tick();
        pll_locked = 1'b1;
        tick();
        n = 0;
        while (hard_reset === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== HOLD + 1 || seq_state !== P_WAIT || rom_loaded !== 1'b0 ||
            reset_cause !== (CAUSE_ON ? 4'b0001 : 4'b0000)) begin
            errors++;
            $display("FAIL lock_relock: got len=%0d st=%0d rom=%b cause=%b", n, seq_state, rom_loaded, reset_cause);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            pll_locked     = ($urandom_range(0, 249) != 0);
            hard_req       = ($urandom_range(0, 79) == 0);
            soft_req       = soft_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
            ioctl_download = ioctl_download ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 69) == 0);
            if ($urandom_range(0, 59) == 0) cfg = 2'($urandom);
            tick();
            checks++;
            if (obs() !== expect_vec()) begin
                errors++;
                $display("FAIL random %0d: got %b want %b", c, obs(), expect_vec());
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_por();
        test_download();
        test_config();
        test_soft();
        test_collision();
        test_async_reset();
        test_lock_loss();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
